// File: rtl/trellis_io_pkg.sv
// rtl/trellis_io_pkg.sv - shared FSM encoding and parameter limits for trellis pad serializers
package trellis_io_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENABLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Legal parameter ranges
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int TA_MIN    = 0;
  localparam int TA_MAX    = 7;

  // One counter serves both bit index (< 32) and turnaround (< 7)
  localparam int CNT_W = 5;

endpackage

// File: rtl/trellis_oser_shreg.sv
// rtl/trellis_oser_shreg.sv - load/shift register presenting the next serial bit
module trellis_oser_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             next_bit
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next register contents; the head of that value is the bit the parent registers onto I
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
    next_bit = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
  end

  // Register update with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/trellis_oser.sv
// rtl/trellis_oser.sv - parallel-to-serial pad driver with tristate turnaround
module trellis_oser
  import trellis_io_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TA        = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic [WIDTH-1:0] D,
  input  logic             DVALID,
  output logic             DREADY,
  output logic             I,
  output logic             T,
  output logic             BUSY,
  output logic             DONE
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("trellis_oser: WIDTH out of range 2..32");
  end
  if (TA < TA_MIN || TA > TA_MAX) begin : g_bad_ta
    $error("trellis_oser: TA out of range 0..7");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_TA  = CNT_W'(TA - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             last_bit;
  logic             ta_done;
  logic             load;
  logic             shift;
  logic             next_bit;

  // Next-state, counter and shift-register control; DREADY is already a flop so accept has no input-to-output path
  always_comb begin
    accept   = DVALID & DREADY;
    last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
    ta_done  = (cnt_q == LAST_TA);
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = (TA == 0) ? ST_SHIFT : ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (ta_done) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = (TA == 0) ? ST_IDLE : ST_RELEASE;
          end
        end else begin
          shift = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (ta_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  trellis_oser_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (CLK),
    .rst      (LSR),
    .load     (load),
    .shift    (shift),
    .din      (D),
    .next_bit (next_bit)
  );

  // State, counter and pad/handshake outputs, all registered from the next state
  always_ff @(posedge CLK) begin
    if (LSR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      T       <= 1'b1;
      I       <= 1'b0;
      DREADY  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      T       <= (state_d == ST_IDLE) || (state_d == ST_RELEASE);
      I       <= (state_d == ST_SHIFT) && next_bit;
      DREADY  <= (state_d == ST_IDLE) || ((state_d == ST_SHIFT) && (cnt_d == LAST_BIT));
      BUSY    <= (state_d != ST_IDLE);
      DONE    <= last_bit;
    end
  end

endmodule

// File: tb/tb_trellis_oser.sv
// tb/tb_trellis_oser.sv - scoreboard bench for trellis_oser
module tb_trellis_oser;

  typedef struct packed {
    logic t;
    logic i;
    logic rdy;
    logic busy;
    logic done;
  } rec_t;

  logic       clk    = 1'b0;
  logic       lsr    = 1'b1;
  logic       dvalid = 1'b0;
  logic [7:0] d      = 8'h00;
  bit         sel    = 1'b0;
  bit         mon_on = 1'b0;
  string      phase  = "startup";

  int n_tests = 0;
  int n_fail  = 0;

  rec_t exp_q[$];
  rec_t e;
  rec_t got;

  logic rdy_a, i_a, t_a, busy_a, done_a;
  logic rdy_b, i_b, t_b, busy_b, done_b;

  trellis_oser #(.WIDTH(8), .TA(1), .MSB_FIRST(1'b0)) dut_a (
    .CLK(clk), .LSR(lsr), .D(d), .DVALID(dvalid), .DREADY(rdy_a),
    .I(i_a), .T(t_a), .BUSY(busy_a), .DONE(done_a)
  );

  trellis_oser #(.WIDTH(8), .TA(0), .MSB_FIRST(1'b1)) dut_b (
    .CLK(clk), .LSR(lsr), .D(d), .DVALID(dvalid), .DREADY(rdy_b),
    .I(i_b), .T(t_b), .BUSY(busy_b), .DONE(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t i rdy busy done) at %0t", tag, obs[4:0], exp[4:0], $time);
    end
  endtask

  function automatic rec_t mk(input logic t, input logic i, input logic r, input logic b, input logic dn);
    return {t, i, r, b, dn};
  endfunction

  // Expected cycles for one accepted word; a chained word skips ENABLE and carries the previous DONE
  task automatic push_bits(input logic [7:0] w, input bit chained);
    int ta;
    ta = sel ? 0 : 1;
    if (!chained) repeat (ta) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(mk(1'b0, sel ? w[7-j] : w[j], (j == 7), 1'b1, (j == 0) && chained));
    end
  endtask

  // Expected cycles after the final bit when nothing follows
  task automatic push_close();
    if (sel) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    end else begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    end
  endtask

  // Compare each cycle against the scoreboard, then extend it for the coming edge
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      got = sel ? {t_b, i_b, rdy_b, busy_b, done_b} : {t_a, i_a, rdy_a, busy_a, done_a};
      check(phase, got, e);
      if (dvalid && e.rdy && !lsr) push_bits(d, !e.t);
      else if (e.rdy && !e.t) push_close();
    end
  end

  // Call at a rising edge
  task automatic apply_reset(input bit hold_valid, input bit next_sel);
    #1 lsr = 1'b1; dvalid = hold_valid; d = 8'h96;
    @(posedge clk);
    sel = next_sel;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    mon_on = 1'b1;
    #1 lsr = 1'b0; dvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] w);
    @(posedge clk); #1 dvalid = 1'b1; d = w;
    @(posedge clk); #1 dvalid = 1'b0; d = 8'h00;
  endtask

  // Hold DVALID with junk on D until the last-bit cycle, then present the second word
  task automatic burst(input logic [7:0] w1, input logic [7:0] w2);
    int ta;
    ta = sel ? 0 : 1;
    @(posedge clk); #1 dvalid = 1'b1; d = w1;
    @(posedge clk);
    for (int c = 0; c < ta + 7; c++) begin
      #1 d = 8'($urandom);
      @(posedge clk);
    end
    #1 d = w2;
    @(posedge clk); #1 dvalid = 1'b0; d = 8'h00;
  endtask

  // DVALID high with junk through ENABLE, non-final SHIFT and RELEASE; w2 only at the next ready edge
  task automatic held(input logic [7:0] w1, input logic [7:0] w2);
    int ta;
    ta = sel ? 0 : 1;
    @(posedge clk); #1 dvalid = 1'b1; d = w1;
    @(posedge clk);
    for (int c = 0; c < ta + 7; c++) begin
      #1 d = 8'($urandom);
      @(posedge clk);
    end
    #1 dvalid = 1'b0;
    @(posedge clk);
    #1 dvalid = 1'b1; d = 8'($urandom);
    repeat (ta) @(posedge clk);
    #1 d = w2;
    @(posedge clk); #1 dvalid = 1'b0; d = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    phase = "reset";      apply_reset(1'b0, 1'b0); idle(3);
    phase = "a_single";   send(8'hA5); idle(12);
    phase = "a_b2b";      burst(8'hA5, 8'h3C); idle(12);
    phase = "a_held";     held(8'h5A, 8'hC3); idle(12);
    phase = "a_rst_prio"; apply_reset(1'b1, 1'b0); idle(4);
    phase = "a_rst_mid";  send(8'hFF); repeat (4) @(posedge clk); apply_reset(1'b0, 1'b0); idle(4);
    phase = "a_random";
    for (int n = 0; n < 3; n++) begin
      send(8'($urandom)); idle(12);
      burst(8'($urandom), 8'($urandom)); idle(12);
    end
    phase = "b_reset";    apply_reset(1'b0, 1'b1); idle(2);
    phase = "b_single";   send(8'h81); idle(10);
    phase = "b_b2b";      burst(8'hA5, 8'h3C); idle(10);
    phase = "b_held";     held(8'h5A, 8'hC3); idle(10);
    phase = "b_rst_mid";  send(8'hFF); repeat (3) @(posedge clk); apply_reset(1'b0, 1'b1); idle(4);
    phase = "b_random";
    for (int n = 0; n < 3; n++) begin
      burst(8'($urandom), 8'($urandom)); idle(10);
    end
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trellis_oser.md
TRELLIS_OSER -- requirements
Module: trellis_oser

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per word; legal range 2..32.
REQ-002 SHALL have parameter TA, default 1: pad turnaround cycles; legal range 0..7.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = LSB shifted first, 1 = MSB shifted first.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock; all flops update on the rising edge.
REQ-005 SHALL have port LSR, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port D, input, WIDTH bits: parallel word to transmit.
REQ-007 SHALL have port DVALID, input, 1 bit: D is valid.
REQ-008 SHALL have port DREADY, output, 1 bit: block accepts D this cycle.
REQ-009 SHALL have port I, output, 1 bit: serial data, connects to the I pin of the pad buffer.
REQ-010 SHALL have port T, output, 1 bit: tristate control, connects to the T pin of the pad buffer; 1 = high-Z.
REQ-011 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse after the last bit of each word.

Function
REQ-013 SHALL drive I, T, DREADY, BUSY and DONE directly from flops, with no combinational path from any input.
REQ-014 SHALL treat a word as accepted at a rising edge where DVALID=1 and DREADY=1; D SHALL be captured at that edge.
REQ-015 SHALL implement a state machine with states IDLE, ENABLE, SHIFT and RELEASE.
REQ-016 IDLE: T=1, I=0, DREADY=1; on accept, SHALL go to ENABLE, or to SHIFT if TA=0.
REQ-017 ENABLE: T=0, I=0, DREADY=0; SHALL last exactly TA cycles, then go to SHIFT.
REQ-018 SHIFT: T=0; I SHALL carry bit j of the word in the j-th SHIFT cycle (j=0..WIDTH-1), in the order set by MSB_FIRST.
REQ-019 Accept at edge k SHALL give T=0 from edge k and bit 0 on I from edge k+TA.
REQ-020 DREADY SHALL be 1 during the last SHIFT cycle (j=WIDTH-1) and 0 in all other SHIFT cycles.
REQ-021 On accept in the last SHIFT cycle, SHALL stay in SHIFT and output the new word's bit 0 on the next cycle, with no ENABLE and no T glitch.
REQ-022 With no accept in the last SHIFT cycle, SHALL go to RELEASE, or to IDLE if TA=0.
REQ-023 RELEASE: T=1, I=0, DREADY=0; SHALL last exactly TA cycles, then go to IDLE.
REQ-024 DVALID during ENABLE, RELEASE or non-final SHIFT cycles SHALL be ignored; D SHALL not be sampled.
REQ-025 DONE SHALL be 1 for exactly one cycle, the cycle after the last bit of each word (including back-to-back words).
REQ-026 Out-of-range WIDTH or TA SHALL cause an elaboration error.

Reset
REQ-027 While LSR=1 at a rising edge, next state SHALL be IDLE with T=1, I=0, DREADY=0, BUSY=0, DONE=0, and counters and shift register cleared.
REQ-028 LSR asserted mid-word SHALL abort the word at the next edge, with no DONE and no further bits.
REQ-029 DREADY SHALL be 1 in the first cycle after LSR deasserts.
REQ-030 LSR SHALL take priority over a simultaneous accept.

Structure
REQ-031 State encoding and the WIDTH/TA legal-range constants SHALL live in shared package trellis_io_pkg.
REQ-032 The load/shift register with MSB_FIRST ordering SHALL be sub-module trellis_oser_shreg; the FSM and counters stay in trellis_oser.

Verification
REQ-033 Base case: WIDTH=8, TA=1, LSB first, D=8'hA5 accepted at edge k -> T=0 at k; I=0 at k; I=1,0,1,0,0,1,0,1 on edges k+1..k+8; T=1 at k+9; DONE=1 at k+9; IDLE at k+10.
REQ-034 Back-to-back: 8'hA5 then 8'h3C held valid -> 16 consecutive bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; T stays 0; DONE pulses twice, 8 cycles apart.
REQ-035 TA=0, MSB_FIRST=1, D=8'h81 at edge k -> I=1 at k, six 0s, 1 at k+7; T=1 and IDLE at k+8.
REQ-036 Reset mid-word: LSR=1 during bit 3 of 8'hFF -> next edge T=1, I=0, BUSY=0, no DONE; DREADY=1 the cycle after LSR drops.
REQ-037 Held valid: DVALID=1 continuously during ENABLE and RELEASE with changing D -> no capture; only D present at DREADY=1 edges is transmitted.
REQ-038 Parameter check: TA=8 or WIDTH=1 -> elaboration fails.
